// File: rtl/cpu_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// cpu_mem_pkg : shared state encoding and default sizes for cpu_mem_responder
// Revision 1.0
// ============================================================================
package cpu_mem_pkg;

  localparam int unsigned DEF_IMEM_AW     = 8;
  localparam int unsigned DEF_DMEM_AW     = 8;
  localparam int unsigned DEF_RELEASE_DLY = 2;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned DLY_W           = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
// mem_array : synchronous-write, asynchronous-read storage (no reset on data)
// Revision 1.0
// ============================================================================
module mem_array #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// cpu_mem_responder : instruction/data memory for the CPU with a streaming
// program-load port; holds the CPU in reset until loading completes.
// Revision 1.0
// ============================================================================
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned IMEM_AW     = DEF_IMEM_AW,
  parameter int unsigned DMEM_AW     = DEF_DMEM_AW,
  parameter int unsigned RELEASE_DLY = DEF_RELEASE_DLY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        MAB_IR,
  output logic [15:0]        MDB_IR,
  input  logic [15:0]        Address_dm,
  input  logic [15:0]        Data_dm,
  input  logic               MemRead,
  input  logic               MemWrite,
  output logic [15:0]        ReadData_dm,
  input  logic               ld_valid,
  input  logic [15:0]        ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               cpu_rst,
  output logic               load_ovf,
  output logic [IMEM_AW:0]   loaded_words
);

  state_e             state_q, state_d;
  logic [IMEM_AW:0]   words_q, words_d;
  logic               ovf_q, ovf_d;
  logic [DLY_W-1:0]   dly_q, dly_d;

  logic               run;
  logic               imem_full;
  logic               imem_we;
  logic               dmem_we;
  logic [DATA_W-1:0]  imem_rdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               unused_addr_bits;

  // words_q doubles as the load pointer; its MSB flags a full imem.
  assign imem_full = words_q[IMEM_AW];
  assign run       = (state_q == ST_RUN);
  assign imem_we   = (state_q == ST_LOAD) & ld_valid & ~imem_full;
  assign dmem_we   = run & MemWrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      words_q <= '0;
      ovf_q   <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    dly_d   = dly_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_valid) begin
          if (imem_full) begin
            ovf_d = 1'b1;
          end else begin
            words_d = words_q + 1'b1;
          end
          if (ld_last) begin
            state_d = ST_HOLD;
            dly_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (dly_q == DLY_W'(RELEASE_DLY - 1)) begin
          state_d = ST_RUN;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  mem_array #(
    .WIDTH (DATA_W),
    .AW    (IMEM_AW)
  ) u_imem (
    .clk     (clk),
    .we_i    (imem_we),
    .waddr_i (words_q[IMEM_AW-1:0]),
    .wdata_i (ld_data),
    .raddr_i (MAB_IR[IMEM_AW-1:0]),
    .rdata_o (imem_rdata)
  );

  mem_array #(
    .WIDTH (DATA_W),
    .AW    (DMEM_AW)
  ) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .waddr_i (Address_dm[DMEM_AW-1:0]),
    .wdata_i (Data_dm),
    .raddr_i (Address_dm[DMEM_AW-1:0]),
    .rdata_o (dmem_rdata)
  );

  // High address bits alias onto the implemented depth.
  assign unused_addr_bits = ^{MAB_IR[15:IMEM_AW], Address_dm[15:DMEM_AW]};

  assign ld_ready     = (state_q == ST_LOAD);
  assign cpu_rst      = ~run;
  assign load_ovf     = ovf_q;
  assign loaded_words = words_q;
  assign MDB_IR       = run ? imem_rdata : '0;
  assign ReadData_dm  = (run & MemRead) ? dmem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_cpu_mem_responder : randomized self-checking bench with behavioural model
// Revision 1.0
// ============================================================================
module tb_cpu_mem_responder;

  localparam int IAW    = 2;
  localparam int DAW    = 4;
  localparam int DLY    = 2;
  localparam int IDEPTH = 4;
  localparam int DDEPTH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [15:0]    MAB_IR = '0;
  logic [15:0]    MDB_IR;
  logic [15:0]    Address_dm = '0;
  logic [15:0]    Data_dm = '0;
  logic           MemRead = 1'b0;
  logic           MemWrite = 1'b0;
  logic [15:0]    ReadData_dm;
  logic           ld_valid = 1'b0;
  logic [15:0]    ld_data = '0;
  logic           ld_last = 1'b0;
  logic           ld_ready;
  logic           cpu_rst;
  logic           load_ovf;
  logic [IAW:0]   loaded_words;

  always #5 clk = ~clk;

  cpu_mem_responder #(
    .IMEM_AW     (IAW),
    .DMEM_AW     (DAW),
    .RELEASE_DLY (DLY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MAB_IR       (MAB_IR),
    .MDB_IR       (MDB_IR),
    .Address_dm   (Address_dm),
    .Data_dm      (Data_dm),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .ReadData_dm  (ReadData_dm),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .cpu_rst      (cpu_rst),
    .load_ovf     (load_ovf),
    .loaded_words (loaded_words)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = loading, 1 = holding, 2 = running.
  logic [15:0] m_imem [IDEPTH];
  bit          m_iv   [IDEPTH];
  logic [15:0] m_dmem [DDEPTH];
  bit          m_dv   [DDEPTH];
  int          m_phase = 0;
  int          m_hold_left = 0;
  int          m_words = 0;
  bit          m_ovf = 1'b0;

  initial begin
    for (int i = 0; i < IDEPTH; i++) m_iv[i] = 1'b0;
    for (int i = 0; i < DDEPTH; i++) m_dv[i] = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = 0;
        m_words = 0;
        m_ovf   = 1'b0;
      end else begin
        case (m_phase)
          0: if (ld_valid) begin
               if (m_words < IDEPTH) begin
                 m_imem[m_words] = ld_data;
                 m_iv[m_words]   = 1'b1;
                 m_words++;
               end else begin
                 m_ovf = 1'b1;
               end
               if (ld_last) begin
                 m_phase     = 1;
                 m_hold_left = DLY;
               end
             end
          1: begin
               m_hold_left--;
               if (m_hold_left == 0) m_phase = 2;
             end
          default: if (MemWrite) begin
               m_dmem[int'(Address_dm) % DDEPTH] = Data_dm;
               m_dv[int'(Address_dm) % DDEPTH]   = 1'b1;
             end
        endcase
      end
    end
  end

  task automatic compare_all();
    bit run;
    int ia;
    int da;
    run = (m_phase == 2);
    ia  = int'(MAB_IR) % IDEPTH;
    da  = int'(Address_dm) % DDEPTH;
    check("ld_ready", 32'(ld_ready), 32'(m_phase == 0));
    check("cpu_rst", 32'(cpu_rst), 32'(!run));
    check("load_ovf", 32'(load_ovf), 32'(m_ovf));
    check("loaded_words", 32'(loaded_words), m_words);
    if (!run) check("MDB_IR_idle", 32'(MDB_IR), 0);
    else if (m_iv[ia]) check("MDB_IR", 32'(MDB_IR), 32'(m_imem[ia]));
    if (!run || !MemRead) check("ReadData_idle", 32'(ReadData_dm), 0);
    else if (m_dv[da]) check("ReadData_dm", 32'(ReadData_dm), 32'(m_dmem[da]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_rst && n < 20) begin
      tick();
      n++;
    end
    check("run_reached", 32'(cpu_rst), 0);
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      MAB_IR     = 16'($urandom);
      Address_dm = 16'($urandom);
      Data_dm    = 16'($urandom);
      MemRead    = 1'($urandom % 2);
      MemWrite   = ($urandom % 3) == 0;
      ld_valid   = 1'($urandom % 2);
      ld_data    = 16'($urandom);
      ld_last    = 1'($urandom % 2);
      tick();
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic gappy_load(input int nwords);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < nwords && guard < 200) begin
      ld_valid = 1'($urandom % 2);
      ld_data  = 16'($urandom);
      ld_last  = ld_valid && (sent == nwords - 1);
      MemWrite = 1'($urandom % 2);
      Address_dm = 16'($urandom);
      Data_dm    = 16'($urandom);
      if (ld_valid) sent++;
      tick();
      guard++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    MemWrite = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_ld_ready", 32'(ld_ready), 1);
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_load_ovf", 32'(load_ovf), 0);
    check("rst_loaded_words", 32'(loaded_words), 0);
    check("rst_MDB_IR", 32'(MDB_IR), 0);
    check("rst_ReadData", 32'(ReadData_dm), 0);
    tick();
    tick();
    rst = 1'b1;

    // Three-word program; a store attempted during load must be ignored.
    MemWrite = 1'b1; Address_dm = 16'd5; Data_dm = 16'hDEAD;
    load_word(16'h01F1, 1'b0);
    load_word(16'h0951, 1'b0);
    load_word(16'h1151, 1'b1);
    check("loaded_3", 32'(loaded_words), 3);
    check("hold_ready", 32'(ld_ready), 0);
    check("hold_cpu_rst0", 32'(cpu_rst), 1);
    tick();
    MemWrite = 1'b0;
    check("hold_cpu_rst1", 32'(cpu_rst), 1);
    tick();
    check("release_cpu_rst", 32'(cpu_rst), 0);

    MAB_IR = 16'd1; #1;
    check("fetch_1", 32'(MDB_IR), 32'h0951);
    MAB_IR = 16'd5; #1;
    check("fetch_alias", 32'(MDB_IR), 32'h0951);
    MAB_IR = 16'd2; #1;
    check("fetch_2", 32'(MDB_IR), 32'h1151);

    Address_dm = 16'd5; Data_dm = 16'hBEEF; MemWrite = 1'b1; MemRead = 1'b0; #1;
    check("read_off", 32'(ReadData_dm), 0);
    tick();
    MemWrite = 1'b0; MemRead = 1'b1; #1;
    check("store_beef", 32'(ReadData_dm), 32'hBEEF);
    MemRead = 1'b0; #1;
    check("read_gated", 32'(ReadData_dm), 0);

    MemRead = 1'b1; MemWrite = 1'b1; Data_dm = 16'h1234; #1;
    check("rw_old", 32'(ReadData_dm), 32'hBEEF);
    tick();
    MemWrite = 1'b0; #1;
    check("rw_new", 32'(ReadData_dm), 32'h1234);
    MemRead = 1'b0;

    random_run(150);

    Address_dm = 16'd7; Data_dm = 16'h7777; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;

    // Reset while running; stores during reload must not reach dmem.
    rst = 1'b0; #1;
    check("rrun_cpu_rst", 32'(cpu_rst), 1);
    check("rrun_ready", 32'(ld_ready), 1);
    tick();
    rst = 1'b1;
    MemWrite = 1'b1; Address_dm = 16'd7; Data_dm = 16'h0000;
    load_word(16'hA5A5, 1'b1);
    tick();
    MemWrite = 1'b0;
    wait_run();
    MemRead = 1'b1; Address_dm = 16'd7; MAB_IR = 16'd0; #1;
    check("dmem_kept", 32'(ReadData_dm), 32'h7777);
    check("reload_fetch", 32'(MDB_IR), 32'hA5A5);
    MemRead = 1'b0;

    // Reset in the middle of HOLD.
    do_reset();
    load_word(16'h1111, 1'b1);
    tick();
    rst = 1'b0; #1;
    check("rhold_cpu_rst", 32'(cpu_rst), 1);
    check("rhold_ready", 32'(ld_ready), 1);
    check("rhold_words", 32'(loaded_words), 0);
    tick();
    rst = 1'b1;
    load_word(16'h3C3C, 1'b1);
    wait_run();
    MAB_IR = 16'd0; #1;
    check("rhold_fetch", 32'(MDB_IR), 32'h3C3C);

    // Load with gaps in ld_valid.
    do_reset();
    gappy_load(3);
    check("gappy_words", 32'(loaded_words), 3);
    wait_run();

    // Overflow: six words into a four-deep imem.
    do_reset();
    for (int i = 0; i < 6; i++) load_word(16'h0A00 + 16'(i), i == 5);
    check("ovf_words", 32'(loaded_words), 4);
    check("ovf_flag", 32'(load_ovf), 1);
    wait_run();
    check("ovf_sticky", 32'(load_ovf), 1);
    MAB_IR = 16'd3; #1;
    check("ovf_fetch3", 32'(MDB_IR), 32'h0A03);
    MAB_IR = 16'd0; #1;
    check("ovf_fetch0", 32'(MDB_IR), 32'h0A00);

    // Randomized sessions.
    for (int s = 0; s < 5; s++) begin
      do_reset();
      gappy_load(int'($urandom_range(1, 6)));
      wait_run();
      random_run(60);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the single-cycle CPU: owns instruction memory (served on `MAB_IR`/`MDB_IR`) and data memory (served on `Address_dm`/`Data_dm`/`MemRead`/`MemWrite`/`ReadData_dm`). Adds a streaming program-load port that fills instruction memory after reset. It holds the CPU in reset until loading completes, then releases it to run. It sits between the test/boot environment and the CPU top, replacing ad-hoc bench drive of `MDB_IR`/`ReadData_dm`.

## Interface
- `IMEM_AW`, default 8: instruction memory word-address width; depth 2^IMEM_AW x 16.
- `DMEM_AW`, default 8: data memory word-address width; depth 2^DMEM_AW x 16.
- `RELEASE_DLY`, default 2: cycles `cpu_rst` stays high after the last load word; legal range 1–15.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `MAB_IR`  in  16  CPU fetch word address; bits above IMEM_AW-1 are ignored (aliasing).
- `MDB_IR`  out  16  instruction word returned to the CPU.
- `Address_dm`  in  16  CPU data word address; bits above DMEM_AW-1 are ignored.
- `Data_dm`  in  16  CPU store data.
- `MemRead`  in  1  CPU load strobe.
- `MemWrite`  in  1  CPU store strobe.
- `ReadData_dm`  out  16  load data returned to the CPU.
- `ld_valid`  in  1  load word valid.
- `ld_data`  in  16  load word.
- `ld_last`  in  1  qualifies the final load word.
- `ld_ready`  out  1  responder accepts a load word.
- `cpu_rst`  out  1  active-high reset to the CPU.
- `load_ovf`  out  1  sticky: a load word was dropped because instruction memory was full.
- `loaded_words`  out  IMEM_AW+1  count of words written into instruction memory.

## Operation
- FSM states: LOAD, HOLD, RUN. Asynchronous reset forces LOAD, load pointer = 0, `loaded_words` = 0, `load_ovf` = 0, delay counter = 0.
- Reset values: `ld_ready` = 1, `cpu_rst` = 1, `load_ovf` = 0, `loaded_words` = 0, `MDB_IR` = 0, `ReadData_dm` = 0.
- LOAD: `ld_ready` = 1. Each handshake (`ld_valid & ld_ready`) writes `ld_data` to imem[pointer], then increments the pointer and `loaded_words`. A handshake with `ld_last` = 1 moves to HOLD.
- Overflow: when `loaded_words` = 2^IMEM_AW, further words are dropped and `load_ovf` is set. A dropped word carrying `ld_last` still moves to HOLD. `load_ovf` clears only on reset.
- HOLD: `ld_ready` = 0, `cpu_rst` = 1. The counter counts RELEASE_DLY cycles, then the FSM moves to RUN.
- RUN: `cpu_rst` = 0 and `ld_ready` = 0. RUN is terminal until reset.
  - `MDB_IR` = imem[`MAB_IR`], combinational.
  - `ReadData_dm` = `MemRead` ? dmem[`Address_dm`] : 0, combinational.
  - `MemWrite` = 1 at a rising edge writes `Data_dm` to dmem[`Address_dm`].
- LOAD/HOLD: `MDB_IR` = 0 and `ReadData_dm` = 0. CPU stores are ignored.
- `MemRead` and `MemWrite` both high: the read returns the old contents and the write lands at the edge.
- Memory contents are not cleared by reset. Unloaded imem locations and unwritten dmem locations are undefined.
- Reset mid-load or mid-run: return immediately to LOAD with `cpu_rst` = 1. Memory keeps its contents. A new load overwrites from address 0.

## Timing
- Load write latency: a word is visible on `MDB_IR` one edge after its handshake, once in RUN.
- Last handshake at edge N: state is HOLD after N, and `cpu_rst` falls after edge N+RELEASE_DLY.
- Fetch and data read: zero-cycle combinational paths. Store: visible to reads after the write edge.
- `ld_ready`, `cpu_rst`, `load_ovf` and `loaded_words` are registered (decoded from state/registers). No combinational path from `ld_valid` to `ld_ready`.

## Structure
- Package `cpu_mem_pkg`: state enumeration (LOAD/HOLD/RUN) and default parameter constants.
- Sub-module `mem_array` (parameterised width and address width; synchronous write, asynchronous read), instantiated once for imem and once for dmem.
- FSM, pointer, delay counter and output muxing live in `cpu_mem_responder`.

## Test plan
- Reset then load 3 words (0x01F1, 0x0951, 0x1151 with `ld_last`) -> `loaded_words` = 3; `cpu_rst` falls 2 cycles after the last handshake; `MAB_IR` = 1 gives `MDB_IR` = 0x0951.
- RUN, store 0xBEEF at address 5, then `MemRead` at 5 -> `ReadData_dm` = 0xBEEF; with `MemRead` = 0 -> 0.
- Simultaneous read/write at address 5 (old 0xBEEF, new 0x1234) -> same cycle reads 0xBEEF, next cycle reads 0x1234.
- IMEM_AW = 2, stream 6 words with last on the 6th -> `loaded_words` = 4, `load_ovf` = 1, RUN reached.
- `ld_valid` toggling with gaps, and `MemWrite` asserted during LOAD -> only handshaken words are stored; dmem is unchanged.
- Reset asserted in RUN and mid-HOLD -> `cpu_rst` = 1 and `ld_ready` = 1 immediately; after reload of 1 word, `MDB_IR` at address 0 = the new word.
